// File: rtl/operand_loader.sv
// Operand loader: fills two operand memories in address order from a valid/ready stream,
// then freezes them for combinational reads until release_i. Optional OPERAND_LOADER_VALID_MASK_EN masks unwritten entries.
module operand_loader #(
  parameter int MEM_DEPTH = 8,
  parameter int MEM_WIDTH = 32,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [MEM_WIDTH-1:0] in_operand1_i,
  input  logic [MEM_WIDTH-1:0] in_operand2_i,
  input  logic [AW-1:0]        operand1_addr_i,
  input  logic [AW-1:0]        operand2_addr_i,
  output logic [MEM_WIDTH-1:0] operand1_o,
  output logic [MEM_WIDTH-1:0] operand2_o,
  output logic                 full_o,
  output logic [AW:0]          fill_count_o,
  input  logic                 release_i
);

  typedef enum logic {LOAD, FULL} state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(MEM_DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(MEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic                full_q, full_d;
  logic                xfer;
  logic                round_clr;
  logic [AW-1:0]       wr_idx;
  logic                addr_ok1, addr_ok2;
  logic                rd_en1, rd_en2;

  logic [MEM_WIDTH-1:0] mem1_q [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] mem2_q [MEM_DEPTH];

  // Ready drops combinationally with reset so a transfer in the reset cycle never lands.
  assign in_ready_o = (state_q == LOAD) && !rst_i;
  assign xfer       = in_valid_i && in_ready_o;
  assign round_clr  = (state_q == FULL) && release_i;
  assign wr_idx     = wr_ptr_q[AW-1:0];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    case (state_q)
      LOAD: begin
        if (xfer) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_C) begin
            state_d = FULL;
            full_d  = 1'b1;
          end
        end
      end
      FULL: begin
        if (release_i) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          full_d   = 1'b0;
        end
      end
      default: begin
        state_d  = LOAD;
        wr_ptr_d = '0;
        full_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
    end
  end

  // Storage is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      mem1_q[wr_idx] <= in_operand1_i;
      mem2_q[wr_idx] <= in_operand2_i;
    end
  end

  assign addr_ok1 = {1'b0, operand1_addr_i} < DEPTH_C;
  assign addr_ok2 = {1'b0, operand2_addr_i} < DEPTH_C;

`ifdef OPERAND_LOADER_VALID_MASK_EN
  logic [MEM_DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (round_clr) begin
      vld_d = '0;
    end else if (xfer) begin
      vld_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign rd_en1 = addr_ok1 && vld_q[operand1_addr_i];
  assign rd_en2 = addr_ok2 && vld_q[operand2_addr_i];
`else
  assign rd_en1 = addr_ok1;
  assign rd_en2 = addr_ok2;
`endif

  assign operand1_o   = rd_en1 ? mem1_q[operand1_addr_i] : '0;
  assign operand2_o   = rd_en2 ? mem2_q[operand2_addr_i] : '0;
  assign full_o       = full_q;
  assign fill_count_o = wr_ptr_q;

endmodule

// File: tb/tb_operand_loader.sv
// Randomized self-checking bench for operand_loader against a queue/array-level round model.
module tb_operand_loader;
  localparam int D  = 8;
  localparam int W  = 32;
  localparam int AW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  in_operand1_i, in_operand2_i;
  logic [AW-1:0] operand1_addr_i, operand2_addr_i;
  logic [W-1:0]  operand1_o, operand2_o;
  logic          full_o;
  logic [AW:0]   fill_count_o;
  logic          release_i;

  int checks = 0;
  int errors = 0;

  // Reference model: number of pairs written this round, full flag, stored contents.
  int           m_cnt;
  bit           m_full;
  logic [W-1:0] m_mem1 [D];
  logic [W-1:0] m_mem2 [D];
  bit           m_known [D];
  bit           m_round [D];

  operand_loader #(.MEM_DEPTH(D), .MEM_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_operand1_i(in_operand1_i), .in_operand2_i(in_operand2_i),
    .operand1_addr_i(operand1_addr_i), .operand2_addr_i(operand2_addr_i),
    .operand1_o(operand1_o), .operand2_o(operand2_o), .full_o(full_o),
    .fill_count_o(fill_count_o), .release_i(release_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear_round();
    m_cnt  = 0;
    m_full = 0;
    for (int i = 0; i < D; i++) m_round[i] = 0;
  endfunction

  function automatic logic [W-1:0] exp_rd1(int a);
`ifdef OPERAND_LOADER_VALID_MASK_EN
    return m_round[a] ? m_mem1[a] : '0;
`else
    return m_mem1[a];
`endif
  endfunction

  function automatic logic [W-1:0] exp_rd2(int a);
`ifdef OPERAND_LOADER_VALID_MASK_EN
    return m_round[a] ? m_mem2[a] : '0;
`else
    return m_mem2[a];
`endif
  endfunction

  function automatic bit rd_known(int a);
`ifdef OPERAND_LOADER_VALID_MASK_EN
    return 1'b1;
`else
    return m_known[a];
`endif
  endfunction

  // Advance one clock; the model applies the round rules to the inputs seen at the edge.
  task automatic tick();
    bit accept;
    bit rel;
    logic [W-1:0] a, b;
    accept = in_valid_i && !m_full && !rst_i;
    rel    = release_i;
    a      = in_operand1_i;
    b      = in_operand2_i;
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      model_clear_round();
    end else if (m_full) begin
      if (rel) model_clear_round();
    end else if (accept) begin
      m_mem1[m_cnt]  = a;
      m_mem2[m_cnt]  = b;
      m_known[m_cnt] = 1;
      m_round[m_cnt] = 1;
      m_cnt++;
      if (m_cnt == D) m_full = 1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1; in_valid_i = 0; release_i = 0;
    in_operand1_i = '0; in_operand2_i = '0;
    operand1_addr_i = '0; operand2_addr_i = '0;
    for (int i = 0; i < D; i++) begin m_known[i] = 0; m_round[i] = 0; end
    model_clear_round();
    #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready_o); end
    tick(); tick();
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
    checks++; if (fill_count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fill_count_o); end
    rst_i = 0;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready_o); end
  endtask

  task automatic test_fill_b2b();
    for (int i = 0; i < D; i++) begin
      in_valid_i = 1; in_operand1_i = W'(i); in_operand2_i = W'(10 + i);
      tick();
      checks++;
      if (fill_count_o !== 4'(i + 1) || full_o !== (i == D - 1)) begin
        errors++;
        $display("FAIL b2b_step%0d: count %0d full %b want count %0d full %b", i, fill_count_o, full_o, i + 1, i == D - 1);
      end
    end
    in_valid_i = 0;
    operand1_addr_i = 3'd5; operand2_addr_i = 3'd5;
    #1;
    checks++;
    if (operand1_o !== 32'd5 || operand2_o !== 32'd15) begin
      errors++; $display("FAIL b2b_read5: got %0d/%0d want 5/15", operand1_o, operand2_o);
    end
  endtask

  task automatic test_hold_full();
    in_valid_i = 1; in_operand1_i = 32'd99; in_operand2_i = 32'd99;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (in_ready_o !== 1'b0 || full_o !== 1'b1 || fill_count_o !== 4'(D)) begin
        errors++; $display("FAIL hold_full%0d: ready %b full %b count %0d want 0/1/%0d", i, in_ready_o, full_o, fill_count_o, D);
      end
    end
    operand1_addr_i = 3'd0; operand2_addr_i = 3'd0;
    #1;
    checks++;
    if (operand1_o !== 32'd0 || operand2_o !== 32'd10) begin
      errors++; $display("FAIL hold_read0: got %0d/%0d want 0/10", operand1_o, operand2_o);
    end
  endtask

  task automatic test_release();
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    in_valid_i = 1; in_operand1_i = a; in_operand2_i = b; release_i = 1;
    tick();
    release_i = 0;
    checks++;
    if (in_ready_o !== 1'b1 || full_o !== 1'b0 || fill_count_o !== 4'd0) begin
      errors++; $display("FAIL release_cycle: ready %b full %b count %0d want 1/0/0", in_ready_o, full_o, fill_count_o);
    end
    tick();
    in_valid_i = 0;
    operand1_addr_i = 3'd0; operand2_addr_i = 3'd0;
    #1;
    checks++;
    if (fill_count_o !== 4'd1 || operand1_o !== a || operand2_o !== b) begin
      errors++; $display("FAIL release_addr0: count %0d rd %h/%h want 1 %h/%h", fill_count_o, operand1_o, operand2_o, a, b);
    end
  endtask

  task automatic fill_and_release();
    in_valid_i = 1;
    while (!m_full) begin
      in_operand1_i = $urandom; in_operand2_i = $urandom;
      tick();
    end
    in_valid_i = 0; release_i = 1;
    tick();
    release_i = 0;
  endtask

  task automatic test_toggle_valid();
    fill_and_release();
    for (int i = 0; i < 6; i++) begin
      in_valid_i = (i % 2 == 0);
      in_operand1_i = $urandom; in_operand2_i = $urandom;
      tick();
    end
    in_valid_i = 0;
    checks++;
    if (fill_count_o !== 4'd3 || full_o !== 1'b0) begin
      errors++; $display("FAIL toggle: count %0d full %b want 3/0", fill_count_o, full_o);
    end
    for (int a = 0; a < 3; a++) begin
      operand1_addr_i = AW'(a); operand2_addr_i = AW'(a);
      #1;
      checks++;
      if (operand1_o !== m_mem1[a] || operand2_o !== m_mem2[a]) begin
        errors++; $display("FAIL toggle_read%0d: got %h/%h want %h/%h", a, operand1_o, operand2_o, m_mem1[a], m_mem2[a]);
      end
    end
  endtask

  task automatic test_reset_midload();
    in_valid_i = 1; in_operand1_i = $urandom; in_operand2_i = $urandom;
    tick();
    checks++;
    if (fill_count_o !== 4'd4) begin errors++; $display("FAIL midload_pre: count %0d want 4", fill_count_o); end
    rst_i = 1;
    model_clear_round();
    #1;
    checks++;
    if (in_ready_o !== 1'b0 || full_o !== 1'b0 || fill_count_o !== 4'd0) begin
      errors++; $display("FAIL midload_async: ready %b full %b count %0d want 0/0/0", in_ready_o, full_o, fill_count_o);
    end
    tick();
    rst_i = 0;
    in_operand1_i = 32'hA5A5_0001; in_operand2_i = 32'h5A5A_0002;
    tick();
    in_valid_i = 0;
    operand1_addr_i = 3'd0; operand2_addr_i = 3'd0;
    #1;
    checks++;
    if (fill_count_o !== 4'd1 || operand1_o !== 32'hA5A5_0001 || operand2_o !== 32'h5A5A_0002) begin
      errors++; $display("FAIL midload_addr0: count %0d rd %h/%h want 1 a5a50001/5a5a0002", fill_count_o, operand1_o, operand2_o);
    end
  endtask

  task automatic test_random();
    int a1, a2;
    for (int c = 0; c < 400; c++) begin
      in_valid_i    = ($urandom_range(0, 9) < 7);
      release_i     = ($urandom_range(0, 9) < 3);
      in_operand1_i = $urandom; in_operand2_i = $urandom;
      tick();
      a1 = $urandom_range(0, D - 1); a2 = $urandom_range(0, D - 1);
      operand1_addr_i = AW'(a1); operand2_addr_i = AW'(a2);
      #1;
      checks++;
      if (in_ready_o !== !m_full || full_o !== m_full || fill_count_o !== 4'(m_cnt)) begin
        errors++; $display("FAIL rand_ctrl%0d: ready %b full %b count %0d want %b/%b/%0d", c, in_ready_o, full_o, fill_count_o, !m_full, m_full, m_cnt);
      end
      if (rd_known(a1)) begin
        checks++;
        if (operand1_o !== exp_rd1(a1)) begin errors++; $display("FAIL rand_rd1_%0d: addr %0d got %h want %h", c, a1, operand1_o, exp_rd1(a1)); end
      end
      if (rd_known(a2)) begin
        checks++;
        if (operand2_o !== exp_rd2(a2)) begin errors++; $display("FAIL rand_rd2_%0d: addr %0d got %h want %h", c, a2, operand2_o, exp_rd2(a2)); end
      end
    end
    in_valid_i = 0; release_i = 0;
  endtask

`ifdef OPERAND_LOADER_VALID_MASK_EN
  task automatic test_valid_mask();
    if (!m_full) fill_and_release();
    else begin release_i = 1; tick(); release_i = 0; end
    if (m_cnt != 0) fill_and_release();
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1; in_operand1_i = $urandom; in_operand2_i = $urandom;
      tick();
    end
    in_valid_i = 0;
    operand1_addr_i = 3'd3; operand2_addr_i = 3'd3;
    #1;
    checks++;
    if (operand1_o !== '0 || operand2_o !== '0) begin
      errors++; $display("FAIL mask_read3: got %h/%h want 0/0", operand1_o, operand2_o);
    end
    operand1_addr_i = 3'd1; operand2_addr_i = 3'd1;
    #1;
    checks++;
    if (operand1_o !== m_mem1[1] || operand2_o !== m_mem2[1]) begin
      errors++; $display("FAIL mask_read1: got %h/%h want %h/%h", operand1_o, operand2_o, m_mem1[1], m_mem2[1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_b2b();
    test_hold_full();
    test_release();
    test_toggle_valid();
    test_reset_midload();
    test_random();
`ifdef OPERAND_LOADER_VALID_MASK_EN
    test_valid_mask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Fills the two operand memories that feed the `operation` stage. Operand pairs arrive over a valid/ready stream and are written in address order, one pair per accepted transfer. Once all `MEM_DEPTH` entries are written, the block holds the memories stable and serves combinational reads at the addresses `operation` drives. A `release_i` pulse starts the next round.

## Interface

Parameters:
- `MEM_DEPTH`, 8, number of operand pairs per round; must be ≥ 2.
- `MEM_WIDTH`, 32, operand width in bits.
- `AW`, local, `$clog2(MEM_DEPTH)`, read/write address width.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `in_valid_i`  in  1  operand pair on `in_operand1_i`/`in_operand2_i` is valid.
- `in_ready_o`  out  1  block accepts a pair this cycle.
- `in_operand1_i`  in  `MEM_WIDTH`  operand 1 of the pair.
- `in_operand2_i`  in  `MEM_WIDTH`  operand 2 of the pair.
- `operand1_addr_i`  in  `AW`  read address, operand 1 memory.
- `operand2_addr_i`  in  `AW`  read address, operand 2 memory.
- `operand1_o`  out  `MEM_WIDTH`  combinational read data, operand 1.
- `operand2_o`  out  `MEM_WIDTH`  combinational read data, operand 2.
- `full_o`  out  1  all `MEM_DEPTH` entries written; memories frozen.
- `fill_count_o`  out  `AW+1`  number of pairs written this round (0..`MEM_DEPTH`).
- `release_i`  in  1  consumer finished; start a new round.

## Operation

- Two states:
  - `LOAD`: the reset state.
  - `FULL`.
- Handshake:
  - Transfer occurs when `in_valid_i && in_ready_o` at the rising edge.
  - `in_ready_o` = (state == `LOAD`) and not `rst_i`.
  - The sender must hold data stable while valid and not ready.
- Write path:
  - On a transfer, `mem1[wr_ptr] <= in_operand1_i`, `mem2[wr_ptr] <= in_operand2_i`, `wr_ptr` increments.
  - `fill_count_o` equals `wr_ptr`.
- `LOAD` → `FULL` on the transfer that writes address `MEM_DEPTH-1`. The pointer does not wrap; `fill_count_o` reads `MEM_DEPTH`.
- `FULL` → `LOAD` when `release_i` is high at an edge. `wr_ptr` returns to 0.
- `release_i` in `LOAD` is ignored.
- `in_valid_i` in `FULL` is ignored, since `in_ready_o` is 0.
- Read path:
  - `operandN_o = memN[operandN_addr_i]`, purely combinational, in any state.
  - Address ≥ `MEM_DEPTH` (non-power-of-2 depth) reads 0.
- Memory contents are not reset; reset clears only control state.

## Timing

- Outputs during and immediately after reset:
  - `in_ready_o` = 0 while `rst_i` is high, and 1 in the first cycle after deassertion.
  - `full_o` = 0.
  - `fill_count_o` = 0.
  - `operandN_o` = memory content (see Configuration).
- Throughput is one pair per cycle with `in_valid_i` held high. `MEM_DEPTH` consecutive cycles fill a round.
- Write-to-read latency: data written at edge N is visible on `operandN_o` after edge N.
- `full_o` rises after the edge of the last transfer and stays high until the edge that samples `release_i`.
- After `release_i`, `in_ready_o` is 1 in the next cycle. Minimum gap between rounds is one cycle.
- `release_i` and `in_valid_i` high together in `FULL`: the release takes effect and the pair is not accepted. The sender retries in `LOAD`.
- Reset asserted mid-load: state goes to `LOAD` and `wr_ptr` to 0 immediately (asynchronous). A transfer in the reset cycle is dropped.

## Configuration

- `OPERAND_LOADER_VALID_MASK_EN`:
  - Defined:
    - Per-entry valid bits track writes.
    - A read of an entry not yet written this round returns 0 on that operand output.
    - Valid bits are cleared by reset and by the `FULL` → `LOAD` transition.
    - Valid bits are set at the write edge.
  - Undefined:
    - No valid bits.
    - Reads return stored content: stale data from the previous round, or X after power-up.

## Test plan

- Reset, then push 8 pairs (i, 10+i) back-to-back with `MEM_DEPTH`=8:
  - `fill_count_o` steps 1..8.
  - `full_o` rises after the 8th edge.
  - Reading address 5 gives 5 / 15.
- Push 3 pairs with `in_valid_i` toggling every other cycle:
  - Only cycles with valid and ready write.
  - `fill_count_o` = 3.
  - `full_o` = 0.
- In `FULL`, hold `in_valid_i` = 1 with pair (99, 99) for 4 cycles:
  - No write.
  - Address 0 still reads the first round's data.
  - `in_ready_o` = 0.
- Pulse `release_i` in `FULL` with `in_valid_i` high:
  - Pair not accepted in the release cycle.
  - `in_ready_o` = 1 next cycle.
  - Next accepted pair lands at address 0.
- Assert `rst_i` after 4 writes:
  - `in_ready_o`, `full_o` and `fill_count_o` go to 0 immediately.
  - After release of reset, the next write goes to address 0.
- With `OPERAND_LOADER_VALID_MASK_EN`, after release write 2 pairs:
  - Address 3 reads 0 / 0.
  - Address 1 reads the newly written pair.
